// File: rtl/lamp_sequence_monitor.sv
`default_nettype none
// ============================================================================
// Module  : lamp_sequence_monitor
// Purpose : Checks the controller's one-hot lamp vector for legality, order and
//           dwell, forwards it while healthy, and flashes amber after a fault.
// Revision: 1.0  initial release
// ============================================================================
module lamp_sequence_monitor #(
  parameter int          T0         = 40,
  parameter int          T1         = 5,
  parameter int          T2         = 20,
  parameter int          T3         = 5,
  parameter int          TOL        = 2,
  parameter int          BLINK_DIV  = 8,
  parameter logic [5:0]  FLASH_MASK = 6'b001010,
  parameter int          SYNC_MAX   = 128
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] z_in,
  input  logic       clear_fault,
  output logic [5:0] lamp_out,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [1:0] phase,
  output logic       in_sync
);

  localparam int c_BLINK_W = $clog2(2 * BLINK_DIV);
  localparam int c_SYNC_W  = $clog2(SYNC_MAX + 1);

  localparam logic [c_BLINK_W-1:0] c_BLINK_HALF = c_BLINK_W'(BLINK_DIV);
  localparam logic [c_BLINK_W-1:0] c_BLINK_LAST = c_BLINK_W'(2 * BLINK_DIV - 1);
  localparam logic [c_SYNC_W-1:0]  c_SYNC_LAST  = c_SYNC_W'(SYNC_MAX - 1);

  localparam logic [5:0] c_PH0_CODE = 6'b000001;

  localparam logic [2:0] c_F_NONE    = 3'd0;
  localparam logic [2:0] c_F_ILLEGAL = 3'd1;
  localparam logic [2:0] c_F_SHORT   = 3'd2;
  localparam logic [2:0] c_F_LONG    = 3'd3;
  localparam logic [2:0] c_F_ORDER   = 3'd4;
  localparam logic [2:0] c_F_TIMEOUT = 3'd5;

  typedef enum logic [1:0] {
    S_SYNC  = 2'd0,
    S_TRACK = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  state_t                 r_state,    w_state_nxt;
  logic [1:0]             r_phase,    w_phase_nxt;
  logic [6:0]             r_dwell,    w_dwell_nxt;
  logic                   r_first,    w_first_nxt;
  logic [c_SYNC_W-1:0]    r_sync_cnt, w_sync_nxt;
  logic [c_BLINK_W-1:0]   r_blink,    w_blink_nxt;
  logic [2:0]             r_code,     w_code_nxt;
  logic [5:0]             r_lamp,     w_lamp_nxt;
  logic                   r_fault;
  logic                   r_in_sync;

  logic       w_legal;
  logic [1:0] w_idx;
  logic [6:0] w_short_lim;
  logic [6:0] w_long_lim;
  logic [6:0] w_dwell_inc;
  logic [2:0] w_flt;

  always_comb begin
    w_legal = 1'b1;
    w_idx   = 2'd0;
    case (z_in)
      6'b000001: w_idx = 2'd0;
      6'b000010: w_idx = 2'd1;
      6'b000100: w_idx = 2'd2;
      6'b001000: w_idx = 2'd3;
      default:   w_legal = 1'b0;
    endcase
  end

  always_comb begin
    w_short_lim = 7'(T0 - TOL);
    w_long_lim  = 7'(T0 + TOL);
    case (r_phase)
      2'd1: begin w_short_lim = 7'(T1 - TOL); w_long_lim = 7'(T1 + TOL); end
      2'd2: begin w_short_lim = 7'(T2 - TOL); w_long_lim = 7'(T2 + TOL); end
      2'd3: begin w_short_lim = 7'(T3 - TOL); w_long_lim = 7'(T3 + TOL); end
      default: ;
    endcase
  end

  assign w_dwell_inc = (r_dwell == 7'd127) ? 7'd127 : r_dwell + 7'd1;

  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_dwell_nxt = r_dwell;
    w_first_nxt = r_first;
    w_sync_nxt  = r_sync_cnt;
    w_code_nxt  = r_code;
    w_flt       = c_F_NONE;
    w_lamp_nxt  = r_lamp;
    w_blink_nxt = r_blink;

    case (r_state)
      S_SYNC: begin
        if (z_in == c_PH0_CODE) begin
          w_state_nxt = S_TRACK;
          w_phase_nxt = 2'd0;
          w_dwell_nxt = 7'd1;
          w_first_nxt = 1'b1;
          w_sync_nxt  = '0;
        end else if (r_sync_cnt == c_SYNC_LAST) begin
          w_flt = c_F_TIMEOUT;
        end else begin
          w_sync_nxt = r_sync_cnt + 1'b1;
        end
      end
      S_TRACK: begin
        // Classification order encodes priority ILLEGAL > ORDER > SHORT > LONG.
        if (!w_legal) begin
          w_flt = c_F_ILLEGAL;
        end else if (w_idx == r_phase) begin
          if (w_dwell_inc > w_long_lim) w_flt = c_F_LONG;
          else                          w_dwell_nxt = w_dwell_inc;
        end else if (w_idx == r_phase + 2'd1) begin
          if (!r_first && (r_dwell < w_short_lim)) begin
            w_flt = c_F_SHORT;
          end else begin
            w_phase_nxt = w_idx;
            w_dwell_nxt = 7'd1;
            w_first_nxt = 1'b0;
          end
        end else begin
          w_flt = c_F_ORDER;
        end
      end
      S_FAULT: begin
        if (clear_fault) begin
          w_state_nxt = S_SYNC;
          w_code_nxt  = c_F_NONE;
          w_sync_nxt  = '0;
        end
      end
      default: w_state_nxt = S_SYNC;
    endcase

    if (w_flt != c_F_NONE) begin
      w_state_nxt = S_FAULT;
      w_code_nxt  = w_flt;
    end

    // Entering a flashing state restarts the blink so flash-on shows immediately.
    if (w_state_nxt == S_TRACK) begin
      w_lamp_nxt  = z_in;
      w_blink_nxt = '0;
    end else if (w_state_nxt != r_state) begin
      w_lamp_nxt  = FLASH_MASK;
      w_blink_nxt = c_BLINK_W'(1);
    end else begin
      w_lamp_nxt  = (r_blink < c_BLINK_HALF) ? FLASH_MASK : 6'b000000;
      w_blink_nxt = (r_blink == c_BLINK_LAST) ? '0 : r_blink + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_SYNC;
      r_phase    <= 2'd0;
      r_dwell    <= 7'd0;
      r_first    <= 1'b1;
      r_sync_cnt <= '0;
      r_blink    <= '0;
      r_code     <= c_F_NONE;
      r_lamp     <= 6'b000000;
      r_fault    <= 1'b0;
      r_in_sync  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_phase    <= w_phase_nxt;
      r_dwell    <= w_dwell_nxt;
      r_first    <= w_first_nxt;
      r_sync_cnt <= w_sync_nxt;
      r_blink    <= w_blink_nxt;
      r_code     <= w_code_nxt;
      r_lamp     <= w_lamp_nxt;
      r_fault    <= (w_state_nxt == S_FAULT);
      r_in_sync  <= (w_state_nxt == S_TRACK);
    end
  end

  assign lamp_out   = r_lamp;
  assign fault      = r_fault;
  assign fault_code = r_code;
  assign phase      = r_phase;
  assign in_sync    = r_in_sync;

endmodule
`default_nettype wire

// File: tb/tb_lamp_sequence_monitor.sv
`default_nettype none
// ============================================================================
// Module  : tb_lamp_sequence_monitor
// Purpose : Vector table, directed corner sequences and randomized traffic
//           against a cycle-level reference model of the lamp monitor.
// Revision: 1.0  initial release
// ============================================================================
module tb_lamp_sequence_monitor;

  logic       clk;
  logic       rst;
  logic [5:0] z_in;
  logic       clear_fault;
  logic [5:0] lamp_out;
  logic       fault;
  logic [2:0] fault_code;
  logic [1:0] phase;
  logic       in_sync;

  lamp_sequence_monitor dut (
    .clk         (clk),
    .rst         (rst),
    .z_in        (z_in),
    .clear_fault (clear_fault),
    .lamp_out    (lamp_out),
    .fault       (fault),
    .fault_code  (fault_code),
    .phase       (phase),
    .in_sync     (in_sync)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: mode 0 = waiting for sync, 1 = tracking, 2 = faulted.
  int         c_T[4] = '{40, 5, 20, 5};
  int         m_mode, m_phase, m_dwell, m_first, m_sync, m_age, m_code;
  logic [5:0] m_lamp;

  function automatic int code_idx(input logic [5:0] z);
    for (int i = 0; i < 4; i++)
      if (z == (6'd1 << i)) return i;
    return -1;
  endfunction

  function automatic logic [5:0] flash(input int age);
    return ((age % 16) < 8) ? 6'b001010 : 6'b000000;
  endfunction

  task automatic model_step(input logic r, input logic [5:0] z, input logic c);
    int k, f;
    if (r) begin
      m_mode = 0; m_phase = 0; m_dwell = 0; m_first = 1;
      m_sync = 0; m_age = -1; m_code = 0; m_lamp = 6'd0;
      return;
    end
    f = 0;
    case (m_mode)
      0: begin
        if (z == 6'b000001) begin
          m_mode = 1; m_phase = 0; m_dwell = 1; m_first = 1; m_sync = 0;
          m_lamp = z;
        end else begin
          m_sync++;
          if (m_sync >= 128) f = 5;
          else begin m_age++; m_lamp = flash(m_age); end
        end
      end
      1: begin
        k = code_idx(z);
        if (k < 0) f = 1;
        else if (k == m_phase) begin
          if (m_dwell + 1 > c_T[m_phase] + 2) f = 3;
          else m_dwell++;
        end else if (k == (m_phase + 1) % 4) begin
          if (m_first == 0 && m_dwell < c_T[m_phase] - 2) f = 2;
          else begin m_phase = k; m_dwell = 1; m_first = 0; end
        end else f = 4;
        if (f == 0) m_lamp = z;
      end
      default: begin
        if (c) begin
          m_mode = 0; m_code = 0; m_sync = 0; m_age = 0; m_lamp = 6'b001010;
        end else begin
          m_age++; m_lamp = flash(m_age);
        end
      end
    endcase
    if (f != 0) begin
      m_mode = 2; m_code = f; m_age = 0; m_lamp = 6'b001010;
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic [5:0] z, input logic c);
    rst = r; z_in = z; clear_fault = c;
    @(posedge clk);
    model_step(r, z, c);
    #1;
    check("lamp_out",   int'(lamp_out),   int'(m_lamp));
    check("fault",      int'(fault),      (m_mode == 2) ? 1 : 0);
    check("fault_code", int'(fault_code), m_code);
    check("phase",      int'(phase),      m_phase);
    check("in_sync",    int'(in_sync),    (m_mode == 1) ? 1 : 0);
  endtask

  task automatic run(input logic [5:0] z, input int n);
    repeat (n) cyc(1'b0, z, 1'b0);
  endtask

  task automatic do_reset();
    cyc(1'b1, 6'd0, 1'b0);
    cyc(1'b1, 6'd0, 1'b0);
  endtask

  task automatic round();
    run(6'b000001, 40); run(6'b000010, 5); run(6'b000100, 20); run(6'b001000, 5);
  endtask

  typedef struct {
    logic       rst;
    logic [5:0] z;
    logic       clr;
    logic [5:0] lamp;
    logic       flt;
    logic [2:0] code;
    logic [1:0] ph;
    logic       sync;
  } vec_t;

  vec_t tv[13];

  initial begin
    int left, cp;
    logic [5:0] z;
    logic       r, c;

    rst = 1'b1; z_in = 6'd0; clear_fault = 1'b0;
    model_step(1'b1, 6'd0, 1'b0);

    //          rst   z          clr   lamp       flt   code  ph    sync
    tv[0]  = '{1'b1, 6'b000000, 1'b0, 6'b000000, 1'b0, 3'd0, 2'd0, 1'b0};
    tv[1]  = '{1'b1, 6'b000001, 1'b1, 6'b000000, 1'b0, 3'd0, 2'd0, 1'b0};
    tv[2]  = '{1'b0, 6'b000000, 1'b0, 6'b001010, 1'b0, 3'd0, 2'd0, 1'b0};
    tv[3]  = '{1'b0, 6'b000001, 1'b0, 6'b000001, 1'b0, 3'd0, 2'd0, 1'b1};
    tv[4]  = '{1'b0, 6'b000001, 1'b1, 6'b000001, 1'b0, 3'd0, 2'd0, 1'b1};
    tv[5]  = '{1'b0, 6'b000010, 1'b0, 6'b000010, 1'b0, 3'd0, 2'd1, 1'b1};
    tv[6]  = '{1'b0, 6'b000100, 1'b0, 6'b001010, 1'b1, 3'd2, 2'd1, 1'b0};
    tv[7]  = '{1'b0, 6'b000011, 1'b0, 6'b001010, 1'b1, 3'd2, 2'd1, 1'b0};
    tv[8]  = '{1'b0, 6'b000000, 1'b1, 6'b001010, 1'b0, 3'd0, 2'd1, 1'b0};
    tv[9]  = '{1'b0, 6'b000001, 1'b0, 6'b000001, 1'b0, 3'd0, 2'd0, 1'b1};
    tv[10] = '{1'b0, 6'b000100, 1'b0, 6'b001010, 1'b1, 3'd4, 2'd0, 1'b0};
    tv[11] = '{1'b1, 6'b000000, 1'b1, 6'b000000, 1'b0, 3'd0, 2'd0, 1'b0};
    tv[12] = '{1'b0, 6'b000000, 1'b0, 6'b001010, 1'b0, 3'd0, 2'd0, 1'b0};

    for (int i = 0; i < 13; i++) begin
      cyc(tv[i].rst, tv[i].z, tv[i].clr);
      check($sformatf("vec%0d", i),
            int'({lamp_out, fault, fault_code, phase, in_sync}),
            int'({tv[i].lamp, tv[i].flt, tv[i].code, tv[i].ph, tv[i].sync}));
    end

    // Nominal rounds, then an illegal code in phase 2 and the flash pattern.
    do_reset();
    round(); round(); round();
    check("nominal_fault", int'(fault), 0);
    check("nominal_sync",  int'(in_sync), 1);
    run(6'b000001, 40); run(6'b000010, 5); run(6'b000100, 10);
    cyc(1'b0, 6'b000011, 1'b0);
    check("illegal_code", int'(fault_code), 1);
    run(6'b000100, 34);

    // Phase 1 held too long.
    do_reset();
    run(6'b000001, 40); run(6'b000010, 7);
    check("long_pre", int'(fault), 0);
    cyc(1'b0, 6'b000010, 1'b0);
    check("long_code", int'(fault_code), 3);

    // Short phase 0 in the second round, then the exempt first phase.
    do_reset();
    round(); run(6'b000001, 30);
    cyc(1'b0, 6'b000010, 1'b0);
    check("short_code", int'(fault_code), 2);
    do_reset();
    run(6'b000001, 30);
    cyc(1'b0, 6'b000010, 1'b0);
    check("first_exempt_fault", int'(fault), 0);
    check("first_exempt_phase", int'(phase), 1);

    // Skipped phase, then a later fault must not overwrite the code.
    do_reset();
    run(6'b000001, 10);
    cyc(1'b0, 6'b000100, 1'b0);
    check("order_code", int'(fault_code), 4);
    cyc(1'b0, 6'b000011, 1'b0);
    check("order_latched", int'(fault_code), 4);

    // Sync timeout, clear, timeout again, reset while faulted.
    do_reset();
    run(6'b000000, 127);
    check("timeout_pre", int'(fault), 0);
    cyc(1'b0, 6'b000000, 1'b0);
    check("timeout_code", int'(fault_code), 5);
    run(6'b000000, 5);
    cyc(1'b0, 6'b000000, 1'b1);
    check("clear_fault", int'(fault), 0);
    run(6'b000000, 130);
    check("refault", int'(fault), 1);
    cyc(1'b1, 6'b000000, 1'b0);
    check("rst_in_fault", int'({lamp_out, fault, fault_code, phase, in_sync}), 0);

    // Randomized controller traffic with glitches, skips, clears and resets.
    do_reset();
    cp = 3; left = 0;
    for (int n = 0; n < 6000; n++) begin
      if (left == 0) begin
        cp   = ($urandom_range(0, 15) == 0) ? (cp + 2) % 4 : (cp + 1) % 4;
        left = c_T[cp] + int'($urandom_range(0, 6)) - 3;
      end
      z = 6'd1 << cp;
      if ($urandom_range(0, 63) == 0) z = 6'($urandom);
      left--;
      c = ($urandom_range(0, 23) == 0);
      r = ($urandom_range(0, 1499) == 0);
      cyc(r, z, c);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lamp_sequence_monitor.md
Name: lamp_sequence_monitor

Overview:
- Safety stage directly downstream of the traffic-light controller.
- Consumes its one-hot 6-bit lamp vector and checks code legality, phase order (0→1→2→3→0) and per-phase dwell time.
- Forwards the vector to the lamp drivers while healthy.
- On any violation, latches a fault code and drives a flashing-amber pattern until the fault is explicitly cleared.

Parameters:
T0, 40, expected dwell of phase 0 (code 6'b000001), in clk cycles
T1, 5, expected dwell of phase 1 (code 6'b000010)
T2, 20, expected dwell of phase 2 (code 6'b000100)
T3, 5, expected dwell of phase 3 (code 6'b001000)
TOL, 2, allowed dwell deviation, in cycles (either direction)
BLINK_DIV, 8, flash half-period, in cycles
FLASH_MASK, 6'b001010, lamp pattern during flash-on
SYNC_MAX, 128, cycles allowed in SYNC before a timeout fault

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
z_in  in  6  lamp vector from controller
clear_fault  in  1  single-cycle pulse; leaves FAULT
lamp_out  out  6  registered lamp drive
fault  out  1  high while in FAULT
fault_code  out  3  0 none, 1 ILLEGAL, 2 SHORT, 3 LONG, 4 ORDER, 5 TIMEOUT
phase  out  2  tracked phase index 0..3
in_sync  out  1  high in TRACK

Behaviour:
- One clock, synchronous active-high reset; rst overrides everything including clear_fault.
- Reset values: lamp_out=0, fault=0, fault_code=0, phase=0, in_sync=0; dwell=0, sync_cnt=0, blink_cnt=0; state=SYNC; first_phase=1.
- All outputs are registered.
- Legal codes: 000001, 000010, 000100, 001000. Any other value, including 0, is illegal.
- Dwell counter: 7 bits, saturates at 127. Every T parameter plus TOL must be ≤ 120.
- States: SYNC, TRACK, FAULT.
- SYNC:
  - lamp_out shows the flash pattern.
  - sync_cnt increments each cycle.
  - z_in==000001 → TRACK, with phase=0, dwell=1, first_phase=1, sync_cnt=0.
  - Any other z_in is ignored.
  - sync_cnt reaches SYNC_MAX without seeing 000001 → FAULT, code 5.
- TRACK:
  - lamp_out = z_in from the previous cycle (1-cycle latency).
  - Each cycle, z_in is classified once, with priority ILLEGAL > ORDER > SHORT > LONG:
    - Illegal code → FAULT, code 1.
    - Legal code that is neither the current phase nor the next phase (skip or reverse) → FAULT, code 4.
    - Next-phase code: if dwell < T[phase]-TOL and first_phase=0 → FAULT, code 2. Otherwise phase advances (mod 4), dwell=1, first_phase=0. The first phase after sync is exempt from SHORT because it may be partial.
    - Current-phase code: dwell+1. If the new dwell > T[phase]+TOL → FAULT, code 3.
- FAULT:
  - The first detected fault latches fault_code; it is not overwritten.
  - fault=1, in_sync=0, phase holds its last value.
  - blink_cnt resets on entry to FAULT or SYNC.
  - lamp_out = FLASH_MASK for BLINK_DIV cycles, then 0 for BLINK_DIV cycles, repeating. Flash-on begins the cycle after detection.
  - clear_fault=1 → SYNC: fault=0, fault_code=0, sync_cnt=0, flash restarts.
  - clear_fault has no effect outside FAULT.
- Simultaneous events:
  - rst together with anything → reset wins.
  - A fault and a phase advance in the same cycle → the fault wins; phase does not advance.
- Reset mid-FAULT or mid-TRACK → all reset values on the next edge. Because SYNC flashes, lamp_out begins flashing the cycle after reset releases.

Test Plan:
- rst 2 cycles, then nominal controller sequence 40/5/20/5 for three full rounds → fault=0, in_sync=1 from the first 000001, phase steps 0,1,2,3, lamp_out equals z_in delayed one cycle.
- In TRACK phase 2, drive z_in=000011 for one cycle → next cycle fault=1, fault_code=1; lamp_out=001010 for 8 cycles, then 000000 for 8 cycles, repeating.
- Hold phase 1 (000010) for 8 cycles → fault raised on the 8th sample (dwell 8 > 7), fault_code=3.
- Second round: phase 0 lasts 30 cycles, then 000010 → fault_code=2. Same stimulus in the first phase after sync → no fault.
- Jump from 000001 directly to 000100 → fault_code=4. During that FAULT, force 000011 → fault_code stays 4.
- After rst, hold z_in=0 → fault_code=5 after 128 cycles. Then pulse clear_fault → SYNC, fault=0. Then assert rst mid-FAULT → all outputs 0 on the next edge.
